// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and helpers for the UART transmit path.
//               - UART_FRAME_BITS : start + 8 data + stop bits per frame
//               - ST_IDLE/ST_WAIT : frame-scheduler state encoding
//               - uart_div()      : clocks per bit from clock and baud rate
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_FRAME_BITS = 10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Clocks per bit; integer floor, identical to what uart_tx uses.
    function automatic int uart_div(input int freq, input int rate);
        return freq / rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Finds the first set bit of
//               req_i searching upward from start_i, wrapping modulo N.
// Ports       : req_i   [N-1:0]  request vector
//               start_i [IW-1:0] index with highest priority
//               found_o          any request set
//               idx_o   [IW-1:0] winning index (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    int k;

    // Walk offsets from the far end back to offset 0 so the closest request
    // to start_i is the last one written and therefore wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        k       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(start_i) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (req_i[IW'(k)]) begin
                found_o = 1'b1;
                idx_o   = IW'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Round-robin arbiter and frame scheduler sharing one uart_tx
//               between N byte producers. Grants one byte per frame, holds
//               off for a full frame, and supports locked multi-byte messages.
// Ports       : clk, rst_n (async, active-low)
//               i_req[N], i_data[N*8], i_last[N] : per-requester byte handshake
//               o_ack[N]  : one-cycle pulse, byte of requester k taken
//               o_data[8], o_start : to uart_tx i_data / i_start
//               o_owner   : index of last granted requester
//               o_busy    : frame in flight or lock held
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int FREQ = 50_000_000,
    parameter int RATE = 115_200,
    parameter int N    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         i_req,
    input  logic [N*8-1:0]       i_data,
    input  logic [N-1:0]         i_last,
    output logic [N-1:0]         o_ack,
    output logic [7:0]           o_data,
    output logic                 o_start,
    output logic [$clog2(N)-1:0] o_owner,
    output logic                 o_busy
);

    localparam int DIV   = uart_div(FREQ, RATE);
    localparam int FRAME = UART_FRAME_BITS * DIV;
    localparam int CW    = $clog2(FRAME);
    localparam int IW    = $clog2(N);

    logic [0:0]    state_q, state_d;
    logic          lock_q,  lock_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [IW-1:0] ptr_q,   ptr_d;     // next round-robin start index
    logic [IW-1:0] owner_q, owner_d;
    logic [N-1:0]  ack_q,   ack_d;
    logic [7:0]    data_q,  data_d;
    logic          start_q, start_d;

    logic [N-1:0]  pick_req;
    logic [IW-1:0] pick_start;
    logic          pick_found;
    logic [IW-1:0] pick_idx;

    // While locked, only the owner is visible to the picker; searching from
    // the owner index then returns the owner or nothing.
    assign pick_req   = lock_q ? (i_req & ({{(N-1){1'b0}}, 1'b1} << owner_q)) : i_req;
    assign pick_start = lock_q ? owner_q : ptr_q;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i   (pick_req),
        .start_i (pick_start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        ack_d   = '0;
        data_d  = data_q;
        start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d         = ST_WAIT;
                    start_d         = 1'b1;
                    ack_d[pick_idx] = 1'b1;
                    data_d          = i_data[{pick_idx, 3'b000} +: 8];
                    owner_d         = pick_idx;
                    ptr_d           = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
                    lock_d          = ~i_last[pick_idx];
                    cnt_d           = '0;
                end
            end
            ST_WAIT: begin
                // Counter is 0 on the o_start cycle, so WAIT spans FRAME cycles.
                if (cnt_q == CW'(FRAME - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            start_q <= start_d;
        end
    end

    assign o_ack   = ack_q;
    assign o_data  = data_q;
    assign o_start = start_q;
    assign o_owner = owner_q;
    assign o_busy  = (state_q == ST_WAIT) | lock_q;

endmodule
`default_nettype wire
